// File: rtl/water_inlet_arbiter.sv
// Shared water-inlet arbiter: round-robin grant of one inlet valve to N_MACH
// washing machines, with a per-grant fill timeout, sticky per-machine fault
// flags and a fixed valve-off settle gap between consecutive grants.
module water_inlet_arbiter #(
  parameter int N_MACH       = 4,
  parameter int FILL_TIMEOUT = 1000,
  parameter int GAP_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_MACH-1:0] fill_req,
  input  logic [N_MACH-1:0] filled,
  input  logic [N_MACH-1:0] fault_clr,
  output logic [N_MACH-1:0] grant,
  output logic              inlet_valve_on,
  output logic [N_MACH-1:0] fill_fault,
  output logic              busy
);

  localparam int IDX_W = (N_MACH > 1) ? $clog2(N_MACH) : 1;
  localparam int TMR_W = $clog2(FILL_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FILL_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_MACH - 1);
  localparam logic [N_MACH-1:0] ONE_HOT0 = N_MACH'(1);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t            state, state_nxt;
  logic [N_MACH-1:0] grant_nxt, fault_nxt, fault_set, eligible;
  logic              valve_nxt, busy_nxt, win_found, release_req;
  logic [TMR_W-1:0]  fill_timer, timer_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [IDX_W-1:0]  last_grant, last_nxt, winner;
  int                rr_idx;

  // Faulted or already-full machines never compete for the inlet.
  assign eligible = fill_req & ~filled & ~fill_fault;

  // While OPEN, last_grant names the machine holding the valve.
  assign release_req = filled[last_grant] | ~fill_req[last_grant];

  // Round-robin pick: first eligible machine after the previous winner.
  always_comb begin
    winner    = last_grant;
    win_found = 1'b0;
    rr_idx    = 0;
    for (int k = 1; k <= N_MACH; k++) begin
      rr_idx = (int'(last_grant) + k) % N_MACH;
      if (!win_found && eligible[IDX_W'(rr_idx)]) begin
        winner    = IDX_W'(rr_idx);
        win_found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    valve_nxt = inlet_valve_on;
    timer_nxt = fill_timer;
    gap_nxt   = gap_cnt;
    last_nxt  = last_grant;
    fault_set = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = OPEN;
          grant_nxt = ONE_HOT0 << winner;
          valve_nxt = 1'b1;
          timer_nxt = '0;
          last_nxt  = winner;
        end
      end
      OPEN: begin
        // A release in the same cycle as the timeout is a normal release.
        if (release_req) begin
          state_nxt = CLOSE;
          grant_nxt = '0;
          valve_nxt = 1'b0;
          gap_nxt   = '0;
        end else if (fill_timer == TMR_LAST) begin
          fault_set[last_grant] = 1'b1;
          state_nxt = CLOSE;
          grant_nxt = '0;
          valve_nxt = 1'b0;
          gap_nxt   = '0;
        end else begin
          timer_nxt = fill_timer + 1'b1;
        end
      end
      CLOSE: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // A fault being set in the same cycle as its clear stays set.
    fault_nxt = (fill_fault & ~fault_clr) | fault_set;
    busy_nxt  = (state_nxt != IDLE);
  end

  // State and output registers; reset drops the valve without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      grant          <= '0;
      inlet_valve_on <= 1'b0;
      fill_fault     <= '0;
      busy           <= 1'b0;
      fill_timer     <= '0;
      gap_cnt        <= '0;
      last_grant     <= IDX_MAX;
    end else begin
      state          <= state_nxt;
      grant          <= grant_nxt;
      inlet_valve_on <= valve_nxt;
      fill_fault     <= fault_nxt;
      busy           <= busy_nxt;
      fill_timer     <= timer_nxt;
      gap_cnt        <= gap_nxt;
      last_grant     <= last_nxt;
    end
  end

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Bench for water_inlet_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_water_inlet_arbiter;

  localparam int N  = 4;
  localparam int TO = 1000;
  localparam int GP = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] fill_req, filled, fault_clr;
  logic [N-1:0] grant, fill_fault;
  logic         inlet_valve_on, busy;

  int checks = 0;
  int errors = 0;

  water_inlet_arbiter #(.N_MACH(N), .FILL_TIMEOUT(TO), .GAP_CYCLES(GP)) dut (
    .clk(clk), .reset(reset), .fill_req(fill_req), .filled(filled),
    .fault_clr(fault_clr), .grant(grant), .inlet_valve_on(inlet_valve_on),
    .fill_fault(fill_fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: who owns the inlet, how long they have held it,
  // how many settle cycles remain, and the round-robin pointer.
  int           m_phase;   // 0 idle, 1 valve open, 2 settling
  int           m_owner, m_last, m_held, m_gap;
  logic [N-1:0] m_fault, m_set, e_grant;
  bit           m_found;
  int           m_idx;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_owner = 0; m_last = N - 1; m_held = 0; m_gap = 0;
      m_fault = '0;
    end else begin
      m_set = '0;
      if (m_phase == 0) begin
        m_found = 0;
        for (int k = 1; k <= N; k++) begin
          m_idx = (m_last + k) % N;
          if (!m_found && fill_req[m_idx[1:0]] && !filled[m_idx[1:0]] && !m_fault[m_idx[1:0]]) begin
            m_found = 1; m_owner = m_idx;
          end
        end
        if (m_found) begin m_phase = 1; m_last = m_owner; m_held = 0; end
      end else if (m_phase == 1) begin
        if (filled[m_owner[1:0]] || !fill_req[m_owner[1:0]]) begin
          m_phase = 2; m_gap = GP;
        end else if (m_held == TO - 1) begin
          m_set[m_owner[1:0]] = 1'b1; m_phase = 2; m_gap = GP;
        end else begin
          m_held++;
        end
      end else begin
        m_gap--;
        if (m_gap == 0) m_phase = 0;
      end
      m_fault = (m_fault & ~fault_clr) | m_set;
    end
    #1;
    e_grant = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
    chk("cmp_grant", grant, e_grant);
    chk("cmp_valve", inlet_valve_on, m_phase == 1);
    chk("cmp_fault", fill_fault, m_fault);
    chk("cmp_busy",  busy, m_phase != 0);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; fill_req = '0; filled = '0; fault_clr = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_valve", inlet_valve_on, 0);
    chk("rst_fault", fill_fault, 0);
    chk("rst_busy",  busy, 0);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 50) begin @(negedge clk); c++; end
    chk(nm, busy, 0);
  endtask

  int on, off, ng, cyc, held, seen;
  logic [N-1:0] prevg;
  logic [N-1:0] seq [5];
  int starts [5];

  initial begin
    reset = 1'b0; fill_req = '0; filled = '0; fault_clr = '0;
    do_reset();

    // Single machine, filled 20 cycles after its grant.
    fill_req = 4'b0001;
    @(negedge clk);
    chk("s31_grant", grant, 4'b0001);
    on = 0;
    for (int c = 0; c < 21; c++) begin
      if (inlet_valve_on) on++;
      if (c == 20) filled = 4'b0001;
      @(negedge clk);
    end
    chk("s31_valve_cycles", on, 21);
    fill_req = '0; filled = '0;
    off = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy && !inlet_valve_on) off++;
      @(negedge clk);
    end
    chk("s31_gap_cycles", off, 4);
    chk("s31_busy_low", busy, 0);

    // All four requesting, each filled after 5 cycles of grant.
    do_reset();
    fill_req = 4'b1111; filled = '0;
    held = 0; ng = 0; cyc = 0; prevg = '0;
    while (ng < 5 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (grant != 0 && grant != prevg) begin
        seq[ng] = grant; starts[ng] = cyc; ng++; held = 0;
      end
      if (grant != 0) begin held++; filled = (held >= 5) ? grant : '0; end
      else filled = '0;
      prevg = grant;
    end
    chk("s32_count", ng, 5);
    chk("s32_seq0", seq[0], 4'b0001);
    chk("s32_seq1", seq[1], 4'b0010);
    chk("s32_seq2", seq[2], 4'b0100);
    chk("s32_seq3", seq[3], 4'b1000);
    chk("s32_seq4", seq[4], 4'b0001);
    for (int i = 0; i < 4; i++) chk("s32_spacing", starts[i+1] - starts[i], 10);
    fill_req = '0; filled = '0;
    wait_idle("s32_idle");

    // Timeout on machine 2, then exclusion until cleared.
    fill_req = 4'b0100; filled = '0; on = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (grant == 4'b0100) on++; else if (on > 0) break;
    end
    chk("s33_open_cycles", on, 1000);
    chk("s33_fault", fill_fault, 4'b0100);
    seen = 0;
    repeat (10) begin @(negedge clk); if (grant != 0) seen++; end
    chk("s33_no_regrant", seen, 0);
    fill_req = 4'b0110;
    seen = 0;
    while (grant == 0 && seen < 10) begin @(negedge clk); seen++; end
    chk("s33_other_grant", grant, 4'b0010);
    fill_req = 4'b0100;
    wait_idle("s33_idle");
    fault_clr = 4'b0100;
    @(negedge clk);
    fault_clr = '0;
    chk("s33_fault_clr", fill_fault, 0);
    @(negedge clk);
    chk("s33_regrant", grant, 4'b0100);
    fill_req = '0;
    @(negedge clk);
    wait_idle("s33_idle2");

    // Filled arrives on the very cycle the timeout would fire.
    fill_req = 4'b0100; filled = '0; on = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (grant == 4'b0100) begin on++; if (on == 1000) filled = 4'b0100; end
      else if (on > 0) break;
    end
    chk("s34_open_cycles", on, 1000);
    chk("s34_no_fault", fill_fault, 0);
    fill_req = '0; filled = '0;
    wait_idle("s34_idle");

    // Timeout and clear of the same machine in the same cycle.
    fill_req = 4'b0010; on = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      fault_clr = '0;
      if (grant == 4'b0010) begin on++; if (on == 1000) fault_clr = 4'b0010; end
      else if (on > 0) break;
    end
    chk("s36_fault_wins", fill_fault, 4'b0010);
    fill_req = '0;
    fault_clr = 4'b0010;
    @(negedge clk);
    fault_clr = '0;
    chk("s36_cleared", fill_fault, 0);
    wait_idle("s36_idle");

    // Reset mid-grant; other requests during OPEN leave the grant alone.
    fill_req = 4'b0001;
    @(negedge clk);
    chk("s35_pre_grant", grant, 4'b0001);
    fill_req = 4'b0011;
    repeat (3) @(negedge clk);
    chk("s35_hold", grant, 4'b0001);
    #2 reset = 1'b0;
    #1;
    chk("s35_async_grant", grant, 0);
    chk("s35_async_valve", inlet_valve_on, 0);
    chk("s35_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("s35_first_grant", grant, 4'b0001);
    fill_req = '0;
    @(negedge clk);
    wait_idle("s35_idle");

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      fault_clr = '0;
      if ($urandom_range(0, 15) == 0) fault_clr = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) fill_req[i] = ~fill_req[i];
        if ($urandom_range(0, 9) == 0) filled[i] = ~filled[i];
      end
      if (grant != 0 && $urandom_range(0, 5) == 0) filled = filled | grant;
      reset = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
    end
    reset = 1'b1; fill_req = '0; filled = '0; fault_clr = '0;
    repeat (3) @(negedge clk);
    wait_idle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/water_inlet_arbiter.md
WATER_INLET_ARBITER -- requirements
Module: water_inlet_arbiter

Interface
REQ-001 Parameters SHALL be: N_MACH, 4, number of washing machines sharing one water inlet (2..8).
REQ-002 Parameters SHALL be: FILL_TIMEOUT, 1000, maximum cycles a grant may be held without filled.
REQ-003 Parameters SHALL be: GAP_CYCLES, 4, inlet valve-off settle cycles between grants (>=1).
REQ-004 Ports SHALL be: clk  in  1  system clock, rising edge.
REQ-005 Ports SHALL be: reset  in  1  asynchronous, active-low reset.
REQ-006 Ports SHALL be: fill_req  in  N_MACH  per-machine fill request, driven from each machine's fill_valve_on; level.
REQ-007 Ports SHALL be: filled  in  N_MACH  per-machine tank-full sensor; level.
REQ-008 Ports SHALL be: fault_clr  in  N_MACH  per-machine fault clear; single-cycle pulse.
REQ-009 Ports SHALL be: grant  out  N_MACH  one-hot or zero; machine currently allowed water.
REQ-010 Ports SHALL be: inlet_valve_on  out  1  master inlet valve drive.
REQ-011 Ports SHALL be: fill_fault  out  N_MACH  sticky per-machine fill timeout flag.
REQ-012 Ports SHALL be: busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 All outputs SHALL be registered; grant SHALL never have more than one bit set.
REQ-014 FSM states SHALL be IDLE, OPEN, and CLOSE.
REQ-015 Eligible set SHALL be fill_req & ~filled & ~fill_fault.
REQ-016 IDLE: if the eligible set is non-empty at edge t, the FSM SHALL enter OPEN at t+1, with grant=winner and inlet_valve_on=1 in the same cycle (1-cycle latency).
REQ-017 Winner SHALL be chosen round-robin: search starts at last_grant+1 mod N_MACH; last_grant SHALL update to the winner on entry to OPEN.
REQ-018 OPEN: fill_timer SHALL clear on entry and increment by 1 each cycle in OPEN; it SHALL be wide enough for FILL_TIMEOUT and SHALL not wrap.
REQ-019 OPEN exit on normal release: if filled[g]=1 or fill_req[g]=0, the FSM SHALL go to CLOSE next cycle, with grant=0, inlet_valve_on=0, and no fault.
REQ-020 OPEN exit on timeout: if fill_timer==FILL_TIMEOUT-1 and filled[g]=0, the FSM SHALL set fill_fault[g] and go to CLOSE next cycle.
REQ-021 Simultaneous release and timeout in OPEN: release SHALL win and no fault SHALL be set.
REQ-022 CLOSE: grant SHALL be 0 and inlet_valve_on SHALL be 0 for exactly GAP_CYCLES cycles, then the FSM SHALL return to IDLE; requests arriving during CLOSE SHALL wait.
REQ-023 Back-to-back operation: with requests pending, the grant-to-grant spacing SHALL be release + GAP_CYCLES + 1 (IDLE) cycles.
REQ-024 fault_clr[i] SHALL clear fill_fault[i] next cycle; a simultaneous set of the same bit SHALL win over the clear.
REQ-025 A faulted machine SHALL be excluded from arbitration until its fault is cleared; other machines SHALL be unaffected.
REQ-026 fill_req bits changing for non-granted machines while in OPEN SHALL have no effect on the current grant.
REQ-027 busy SHALL be 1 in OPEN and CLOSE, and 0 in IDLE.

Reset
REQ-028 reset=0 SHALL asynchronously force the FSM to IDLE and set grant=0, inlet_valve_on=0, fill_fault=0, busy=0, fill_timer=0, gap counter=0, and last_grant=N_MACH-1 (machine 0 wins first).
REQ-029 Reset asserted mid-OPEN SHALL drop grant and inlet_valve_on immediately, without waiting for a clock edge.
REQ-030 Operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-031 Scenario: fill_req=0001, filled rises 20 cycles after grant -> grant=0001 one cycle after the request; valve on for 21 cycles; 4 cycles with valve off; busy then falls.
REQ-032 Scenario: fill_req=1111 held, each filled after 5 cycles -> grant order 0001, 0010, 0100, 1000, 0001; grants separated by the 4-cycle gap plus 1 IDLE cycle.
REQ-033 Scenario: fill_req=0100, filled held 0, FILL_TIMEOUT=1000 -> grant drops after 1000 OPEN cycles; fill_fault=0100; machine 2 not regranted until fault_clr=0100.
REQ-034 Scenario: filled[g] rises on the same cycle fill_timer==FILL_TIMEOUT-1 -> normal release; fill_fault stays 0.
REQ-035 Scenario: reset pulsed low for 3 cycles mid-OPEN -> grant=0 and inlet_valve_on=0 asynchronously; the first grant after release goes to machine 0 when fill_req=0011.
REQ-036 Scenario: fault_clr=0010 and a timeout fault on machine 1 in the same cycle -> fill_fault[1]=1.
